cla_pipe_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder; successor to the fixed 4-bit registered CLA adder.
- Operand split into GROUP-bit CLA groups; one group resolved per pipeline stage, carry handed between stages through registers.
- Valid/ready stream interface on both sides; one add per cycle sustained.
- Adds zero and signed-overflow flags.

---
 rtl/cla_pipe_adder.sv | 175 +++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: one GROUP-bit lookahead group resolved per stage,
// valid/ready handshake on both sides. Define CLA_PIPE_ADDER_SUB_EN to add a 'sub' input (a - b).
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_PIPE_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_param_check
    $fatal(1, "cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
  end

  // Flattened lookahead: carry i+1 is an OR of generate terms masked by propagate chains.
  function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] x,
                                                 input logic [GROUP-1:0] y,
                                                 input logic             ci);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      term = ci;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
`ifdef CLA_PIPE_ADDER_SUB_EN
    b_eff    = sub ? ~b : b;
    cin_eff  = sub ? 1'b1 : cin;
`else
    b_eff    = b;
    cin_eff  = cin;
`endif
  end

  genvar gi;
  for (gi = 0; gi < NG; gi++) begin : g_stage
    localparam int IW = WIDTH - gi * GROUP;  // operand bits still unresolved on entry
    localparam int SW = (gi + 1) * GROUP;    // sum bits known after this stage

    logic [IW-1:0]    op_a;
    logic [IW-1:0]    op_b;
    logic             c_in;
    logic             v_in;
    logic [GROUP:0]   c;
    logic [GROUP-1:0] grp_sum;
    logic [SW-1:0]    sum_new;
    logic             load;
    logic [SW-1:0]    sum_d, sum_q;
    logic             carry_d, carry_q;
    logic             valid_d, valid_q;

    if (gi == 0) begin : g_head
      assign op_a    = a;
      assign op_b    = b_eff;
      assign c_in    = cin_eff;
      assign v_in    = in_valid;
      assign sum_new = grp_sum;
    end else begin : g_chain
      assign op_a    = g_stage[gi-1].g_rem.rem_a_q;
      assign op_b    = g_stage[gi-1].g_rem.rem_b_q;
      assign c_in    = g_stage[gi-1].carry_q;
      assign v_in    = g_stage[gi-1].valid_q;
      assign sum_new = {grp_sum, g_stage[gi-1].sum_q};
    end

    always_comb begin
      c       = cla_carries(op_a[GROUP-1:0], op_b[GROUP-1:0], c_in);
      grp_sum = op_a[GROUP-1:0] ^ op_b[GROUP-1:0] ^ c[GROUP-1:0];
    end

    // Data only loads for valid slots, so bubbles leave the last result untouched.
    always_comb begin
      load    = adv && v_in;
      valid_d = adv ? v_in : valid_q;
      carry_d = load ? c[GROUP] : carry_q;
      sum_d   = load ? sum_new : sum_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    if (gi < NG - 1) begin : g_rem
      logic [IW-GROUP-1:0] rem_a_d, rem_a_q;
      logic [IW-GROUP-1:0] rem_b_d, rem_b_q;

      always_comb begin
        rem_a_d = load ? op_a[IW-1:GROUP] : rem_a_q;
        rem_b_d = load ? op_b[IW-1:GROUP] : rem_b_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem_a_q <= '0;
          rem_b_q <= '0;
        end else begin
          rem_a_q <= rem_a_d;
          rem_b_q <= rem_b_d;
        end
      end
    end

    if (gi == NG - 1) begin : g_flags
      logic ovf_d, ovf_q;
      logic zero_d, zero_q;

      // Signed overflow: carry into the MSB disagrees with carry out of it.
      always_comb begin
        ovf_d  = load ? (c[GROUP] ^ c[GROUP-1]) : ovf_q;
        zero_d = load ? (sum_new == '0) : zero_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  assign out_valid = g_stage[NG-1].valid_q;
  assign sum       = g_stage[NG-1].sum_q;
  assign cout      = g_stage[NG-1].carry_q;
  assign ovf       = g_stage[NG-1].g_flags.ovf_q;
  assign zero      = g_stage[NG-1].g_flags.zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder (WIDTH=16, GROUP=4): reset, carry/overflow corners,
// streaming, backpressure, mid-stream reset, and subtract when CLA_PIPE_ADDER_SUB_EN is defined.
module tb_cla_pipe_adder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;
`ifdef CLA_PIPE_ADDER_SUB_EN
  logic         sub;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic         cout;
    logic         ovf;
    logic         zero;
    logic [W-1:0] sum;
  } res_t;

  res_t exp_q[$];

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef CLA_PIPE_ADDER_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] t;
    res_t       r;
    t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic res_t outs();
    res_t r;
    r.cout = cout;
    r.ovf  = ovf;
    r.zero = zero;
    r.sum  = sum;
    return r;
  endfunction

  // One op into an empty pipe; checks latency and the {cout,ovf,zero,sum} result.
  task automatic single(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input res_t e);
    int cyc;
    a = x; b = y; cin = c; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, cyc, 4);
    chk({tag, " result"}, outs(), e);
    $display("txn %s: a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b zero=%b",
             tag, x, y, c, sum, cout, ovf, zero);
    @(posedge clk); #1;
    chk({tag, " drained"}, out_valid, 1'b0);
  endtask

  // Streams n random ops; holds out_ready low for stall_len cycles once a result appears.
  task automatic stream(input string tag, input int n, input int stall_len);
    int           sent    = 0;
    int           got     = 0;
    int           stalled = 0;
    int           first   = -1;
    int           last    = -1;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    res_t         r;
    exp_q.delete();
    va = W'($urandom); vb = W'($urandom); vc = 1'b0;
    for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
      out_ready = (stalled >= stall_len);
      in_valid  = (sent < n);
      a = va; b = vb; cin = vc;
      @(negedge clk);
      if (out_valid && !out_ready) begin
        chk({tag, " in_ready during stall"}, in_ready, 1'b0);
        stalled++;
      end
      if (in_valid && stall_len == 0) chk({tag, " in_ready"}, in_ready, 1'b1);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(va, vb, vc));
        sent++;
        va = W'($urandom); vb = W'($urandom); vc = (sent % 2 == 1);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk({tag, " spurious out_valid"}, out_valid, 1'b0);
        end else begin
          chk({tag, " result"}, outs(), exp_q[0]);
          if (out_ready) begin
            r = exp_q.pop_front();
            $display("txn %s #%0d: sum=%h cout=%b ovf=%b zero=%b", tag, got, r.sum, r.cout,
                     r.ovf, r.zero);
            got++;
            if (first < 0) first = cyc;
            last = cyc;
          end
        end
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, " count"}, got, n);
    if (stall_len == 0) chk({tag, " rate"}, last - first, n - 1);
    else chk({tag, " stall cycles"}, stalled, stall_len);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
`ifdef CLA_PIPE_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset sum", sum, 16'h0000);
    chk("reset cout", cout, 1'b0);
    chk("reset ovf", ovf, 1'b0);
    chk("reset zero", zero, 1'b0);
    chk("reset in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    single("ffff+1", 16'hFFFF, 16'h0001, 1'b0, '{1'b1, 1'b0, 1'b1, 16'h0000});
    single("7fff+1", 16'h7FFF, 16'h0001, 1'b0, '{1'b0, 1'b1, 1'b0, 16'h8000});
    single("8000+8000", 16'h8000, 16'h8000, 1'b0, '{1'b1, 1'b1, 1'b1, 16'h0000});
    single("1234+4321+1", 16'h1234, 16'h4321, 1'b1, '{1'b0, 1'b0, 1'b0, 16'h5556});
    single("0fff+0+1", 16'h0FFF, 16'h0000, 1'b1, '{1'b0, 1'b0, 1'b0, 16'h1000});

    stream("stream", 20, 0);
    stream("bp", 8, 5);

    // Mid-stream reset with a result sitting at the output.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 16'h1111 * i[15:0]; b = 16'h0101; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre-reset out_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", out_valid, 1'b0);
    chk("async reset sum", sum, 16'h0000);
    chk("async reset flags", {cout, ovf, zero}, 3'b000);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("post-reset no out_valid", seen, 0);
    single("after reset", 16'hABCD, 16'h1234, 1'b0, '{1'b0, 1'b0, 1'b0, 16'hBE01});

`ifdef CLA_PIPE_ADDER_SUB_EN
    sub = 1'b1;
    single("5-7", 16'h0005, 16'h0007, 1'b0, '{1'b0, 1'b0, 1'b0, 16'hFFFE});
    single("8000-1", 16'h8000, 16'h0001, 1'b1, '{1'b1, 1'b1, 1'b0, 16'h7FFF});
    sub = 1'b0;
    single("sub0 add", 16'h0005, 16'h0007, 1'b1, '{1'b0, 1'b0, 1'b0, 16'h000D});
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
